// File: rtl/trap_ctrl_if.sv
// Bundle of trap/mret request handshakes, the redirect to fetch and the machine
// CSR file port. The slave modport belongs to trap_ctrl; master is the surrounding core.
interface trap_ctrl_if;
    logic        trap_req_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic        mret_req_i;
    logic        trap_ack_o;
    logic        mret_ack_o;
    logic        busy_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_we_o;
    logic        csr_re_o;
    logic [31:0] csr_rdata_i;
    logic [3:0]  dbg_state_o;

    modport slave (
        input  trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, csr_rdata_i,
        output trap_ack_o, mret_ack_o, busy_o, redirect_valid_o, redirect_pc_o,
        output csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o, dbg_state_o
    );

    modport master (
        output trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, csr_rdata_i,
        input  trap_ack_o, mret_ack_o, busy_o, redirect_valid_o, redirect_pc_o,
        input  csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o, dbg_state_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: walks mstatus/mepc/mcause/mtvec through the
// CSR file port one access per cycle and ends with a single-cycle PC redirect.
module trap_ctrl #(
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [11:0] CSR_MTVEC   = 12'h305
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    trap_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        T_RD_MST = 4'd1,
        T_WT_MST = 4'd2,
        T_WR_EPC = 4'd3,
        T_WR_CAU = 4'd4,
        T_WR_MST = 4'd5,
        T_RD_TV  = 4'd6,
        T_WT_TV  = 4'd7,
        M_RD_MST = 4'd8,
        M_WT_MST = 4'd9,
        M_WR_MST = 4'd10,
        M_RD_EPC = 4'd11,
        M_WT_EPC = 4'd12,
        REDIR    = 4'd13
    } state_e;

    state_e      state_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] mst_q;
    logic [11:0] csr_addr_q;
    logic [31:0] csr_wdata_q;
    logic        csr_we_q;
    logic        csr_re_q;
    logic        redir_valid_q;
    logic [31:0] redir_pc_q;

    logic [31:0] trap_mst_d;
    logic [31:0] mret_mst_d;
    logic [31:0] tvec_base_d;
    logic [31:0] trap_target_d;
    logic        idle;

    // Requests are level-held by the requester; the matching ack is a combinational
    // one-cycle pulse in the IDLE cycle that accepts it, trap winning over mret.
    assign idle           = (state_q == IDLE);
    assign bus.trap_ack_o = rst_ni && idle && bus.trap_req_i;
    assign bus.mret_ack_o = rst_ni && idle && bus.mret_req_i && !bus.trap_req_i;

    always_comb begin
        trap_mst_d         = mst_q;
        trap_mst_d[7]      = mst_q[3];
        trap_mst_d[3]      = 1'b0;
        trap_mst_d[12:11]  = 2'b11;

        mret_mst_d         = bus.csr_rdata_i;
        mret_mst_d[3]      = bus.csr_rdata_i[7];
        mret_mst_d[7]      = 1'b1;
        mret_mst_d[12:11]  = 2'b11;

        // Vectored offset only applies to interrupts; reserved modes fall back to direct.
        tvec_base_d   = bus.csr_rdata_i & ~32'd3;
        trap_target_d = tvec_base_d;
        if (VECTORED_EN && (bus.csr_rdata_i[1:0] == 2'b01) && cause_q[31])
            trap_target_d = tvec_base_d + {25'd0, cause_q[4:0], 2'b00};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cause_q       <= '0;
            epc_q         <= '0;
            mst_q         <= '0;
            csr_addr_q    <= '0;
            csr_wdata_q   <= '0;
            csr_we_q      <= 1'b0;
            csr_re_q      <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            csr_addr_q    <= '0;
            csr_wdata_q   <= '0;
            csr_we_q      <= 1'b0;
            csr_re_q      <= 1'b0;
            redir_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.trap_req_i) begin
                        cause_q    <= bus.trap_cause_i;
                        epc_q      <= bus.trap_pc_i & ~32'd3;
                        csr_re_q   <= 1'b1;
                        csr_addr_q <= CSR_MSTATUS;
                        state_q    <= T_RD_MST;
                    end else if (bus.mret_req_i) begin
                        csr_re_q   <= 1'b1;
                        csr_addr_q <= CSR_MSTATUS;
                        state_q    <= M_RD_MST;
                    end
                end
                T_RD_MST: state_q <= T_WT_MST;
                T_WT_MST: begin
                    mst_q       <= bus.csr_rdata_i;
                    csr_we_q    <= 1'b1;
                    csr_addr_q  <= CSR_MEPC;
                    csr_wdata_q <= epc_q;
                    state_q     <= T_WR_EPC;
                end
                T_WR_EPC: begin
                    csr_we_q    <= 1'b1;
                    csr_addr_q  <= CSR_MCAUSE;
                    csr_wdata_q <= cause_q;
                    state_q     <= T_WR_CAU;
                end
                T_WR_CAU: begin
                    csr_we_q    <= 1'b1;
                    csr_addr_q  <= CSR_MSTATUS;
                    csr_wdata_q <= trap_mst_d;
                    state_q     <= T_WR_MST;
                end
                T_WR_MST: begin
                    csr_re_q   <= 1'b1;
                    csr_addr_q <= CSR_MTVEC;
                    state_q    <= T_RD_TV;
                end
                T_RD_TV: state_q <= T_WT_TV;
                T_WT_TV: begin
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= trap_target_d;
                    state_q       <= REDIR;
                end
                M_RD_MST: state_q <= M_WT_MST;
                M_WT_MST: begin
                    csr_we_q    <= 1'b1;
                    csr_addr_q  <= CSR_MSTATUS;
                    csr_wdata_q <= mret_mst_d;
                    state_q     <= M_WR_MST;
                end
                M_WR_MST: begin
                    csr_re_q   <= 1'b1;
                    csr_addr_q <= CSR_MEPC;
                    state_q    <= M_RD_EPC;
                end
                M_RD_EPC: state_q <= M_WT_EPC;
                M_WT_EPC: begin
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= bus.csr_rdata_i & ~32'd3;
                    state_q       <= REDIR;
                end
                REDIR:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o           = !idle;
    assign bus.redirect_valid_o = redir_valid_q;
    assign bus.redirect_pc_o    = redir_pc_q;
    assign bus.csr_addr_o       = {20'd0, csr_addr_q};
    assign bus.csr_wdata_o      = csr_wdata_q;
    assign bus.csr_we_o         = csr_we_q;
    assign bus.csr_re_o         = csr_re_q;
    assign bus.dbg_state_o      = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a small CSR-file model answers reads one cycle
// after csr_re_o and logs every write for comparison against hand-computed values.
module tb_trap_ctrl;

    logic clk;
    logic rst_n;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int redir_cnt = 0;

    logic [31:0] csr_mem [logic [11:0]];
    logic [43:0] exp_q[$];
    logic [43:0] wr_q[$];
    logic        rd_pend = 1'b0;
    logic [11:0] rd_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CSR file model plus per-cycle port rules, all sampled on the falling edge.
    always @(negedge clk) begin
        bus.csr_rdata_i = rd_pend ? csr_mem[rd_addr] : 32'hA5A5_5A5A;
        rd_pend = bus.csr_re_o;
        rd_addr = bus.csr_addr_o[11:0];
        check("we_re_excl", {bus.csr_we_o, bus.csr_re_o} == 2'b11, 0);
        if (!bus.csr_we_o && !bus.csr_re_o) begin
            check("idle_addr", bus.csr_addr_o, 0);
            check("idle_wdata", bus.csr_wdata_o, 0);
        end
        if (bus.busy_o)
            check("ack_busy", {bus.trap_ack_o, bus.mret_ack_o}, 0);
        if (bus.csr_we_o) begin
            csr_mem[bus.csr_addr_o[11:0]] = bus.csr_wdata_o;
            wr_q.push_back({bus.csr_addr_o[11:0], bus.csr_wdata_o});
        end
        if (bus.redirect_valid_o) redir_cnt++;
    end

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wr_q.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_q.size() > 0)
            check({tag, "_wr"}, wr_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        wr_q.delete();
    endtask

    // Waits (bounded) for the redirect pulse; lat counts falling edges after the accept cycle.
    task automatic wait_redir(input bit drop, inout int lat);
        bit seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && drop) begin
                bus.trap_req_i = 1'b0;
                bus.mret_req_i = 1'b0;
            end
            seen = bus.redirect_valid_o;
        end
    endtask

    task automatic run_seq(input bit is_trap, input logic [31:0] cause, input logic [31:0] pc,
                           input int exp_lat, input logic [31:0] exp_pc, input string tag);
        int lat = 0;
        @(negedge clk);
        if (is_trap) begin
            bus.trap_req_i   = 1'b1;
            bus.trap_cause_i = cause;
            bus.trap_pc_i    = pc;
        end else begin
            bus.mret_req_i = 1'b1;
        end
        #1;
        check({tag, "_ack"}, is_trap ? bus.trap_ack_o : bus.mret_ack_o, 1);
        wait_redir(1'b1, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_pc"}, bus.redirect_pc_o, exp_pc);
        @(negedge clk);
        check({tag, "_pulse"}, bus.redirect_valid_o, 0);
        check({tag, "_idle"}, bus.busy_o, 0);
        check({tag, "_hold"}, bus.redirect_pc_o, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n            = 1'b0;
        bus.trap_req_i   = 1'b0;
        bus.trap_cause_i = '0;
        bus.trap_pc_i    = '0;
        bus.mret_req_i   = 1'b0;
        csr_mem[12'h300] = 32'h0;
        csr_mem[12'h341] = 32'h0;
        csr_mem[12'h342] = 32'h0;
        csr_mem[12'h305] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy_o, 0);
        check("rst_rv", bus.redirect_valid_o, 0);
        check("rst_rpc", bus.redirect_pc_o, 0);
        check("rst_we", bus.csr_we_o, 0);
        check("rst_re", bus.csr_re_o, 0);
        check("rst_acks", {bus.trap_ack_o, bus.mret_ack_o}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_q.delete();

        // Direct trap
        csr_mem[12'h300] = 32'h0000_0008;
        csr_mem[12'h305] = 32'h0000_1000;
        exp_q.push_back({12'h341, 32'h0000_0204});
        exp_q.push_back({12'h342, 32'h0000_0002});
        exp_q.push_back({12'h300, 32'h0000_1880});
        run_seq(1'b1, 32'h0000_0002, 32'h0000_0206, 8, 32'h0000_1000, "direct");
        check_writes("direct");

        // Vectored interrupt
        csr_mem[12'h300] = 32'h0;
        csr_mem[12'h305] = 32'h0000_2001;
        exp_q.push_back({12'h341, 32'h0000_0400});
        exp_q.push_back({12'h342, 32'h8000_0007});
        exp_q.push_back({12'h300, 32'h0000_1800});
        run_seq(1'b1, 32'h8000_0007, 32'h0000_0400, 8, 32'h0000_201C, "vect");
        check_writes("vect");

        // Exception with vectored mtvec stays at base
        exp_q.push_back({12'h341, 32'h0000_0120});
        exp_q.push_back({12'h342, 32'h0000_0005});
        exp_q.push_back({12'h300, 32'h0000_1800});
        run_seq(1'b1, 32'h0000_0005, 32'h0000_0123, 8, 32'h0000_2000, "vexc");
        check_writes("vexc");

        // Reserved mode 2'b11 acts as direct
        csr_mem[12'h305] = 32'h0000_3003;
        run_seq(1'b1, 32'h8000_0003, 32'h0000_0010, 8, 32'h0000_3000, "mode3");
        wr_q.delete();

        // Vectored target wraps modulo 2^32
        csr_mem[12'h305] = 32'hFFFF_FFFD;
        run_seq(1'b1, 32'h8000_001F, 32'h0000_0020, 8, 32'h0000_0078, "wrap");
        wr_q.delete();

        // mret
        csr_mem[12'h300] = 32'h0000_1880;
        csr_mem[12'h341] = 32'h0000_0300;
        exp_q.push_back({12'h300, 32'h0000_1888});
        run_seq(1'b0, 32'h0, 32'h0, 6, 32'h0000_0300, "mret");
        check_writes("mret");

        // Simultaneous trap and mret: trap first, mret in the IDLE cycle after REDIR
        csr_mem[12'h300] = 32'h0000_0008;
        csr_mem[12'h305] = 32'h0000_1000;
        @(negedge clk);
        bus.trap_req_i   = 1'b1;
        bus.trap_cause_i = 32'h0000_000B;
        bus.trap_pc_i    = 32'h0000_0500;
        bus.mret_req_i   = 1'b1;
        #1;
        check("sim_tack", bus.trap_ack_o, 1);
        check("sim_mack0", bus.mret_ack_o, 0);
        lat = 0;
        @(negedge clk);
        lat = 1;
        bus.trap_req_i = 1'b0;
        wait_redir(1'b0, lat);
        check("sim_tlat", lat, 8);
        check("sim_tpc", bus.redirect_pc_o, 32'h0000_1000);
        @(negedge clk);
        check("sim_mack1", bus.mret_ack_o, 1);
        check("sim_tack1", bus.trap_ack_o, 0);
        lat = 0;
        wait_redir(1'b1, lat);
        check("sim_mlat", lat, 6);
        check("sim_mpc", bus.redirect_pc_o, 32'h0000_0500);
        exp_q.push_back({12'h341, 32'h0000_0500});
        exp_q.push_back({12'h342, 32'h0000_000B});
        exp_q.push_back({12'h300, 32'h0000_1880});
        exp_q.push_back({12'h300, 32'h0000_1888});
        @(negedge clk);
        check_writes("sim");

        // Async reset while writing mcause
        @(negedge clk);
        bus.trap_req_i   = 1'b1;
        bus.trap_cause_i = 32'h0000_0003;
        bus.trap_pc_i    = 32'h0000_0600;
        #1;
        check("rstm_ack", bus.trap_ack_o, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.trap_req_i = 1'b0;
        end
        check("rstm_we", bus.csr_we_o, 1);
        check("rstm_addr", bus.csr_addr_o, 32'h342);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_we0", bus.csr_we_o, 0);
        check("rstm_addr0", bus.csr_addr_o, 0);
        check("rstm_wd0", bus.csr_wdata_o, 0);
        check("rstm_busy0", bus.busy_o, 0);
        check("rstm_rpc0", bus.redirect_pc_o, 0);
        lat = redir_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rstm_noredir", redir_cnt, lat);
        check("rstm_idle", bus.dbg_state_o, 0);
        wr_q.delete();
        csr_mem[12'h300] = 32'h0000_0008;
        exp_q.push_back({12'h341, 32'h0000_0600});
        exp_q.push_back({12'h342, 32'h0000_0003});
        exp_q.push_back({12'h300, 32'h0000_1880});
        run_seq(1'b1, 32'h0000_0003, 32'h0000_0600, 8, 32'h0000_1000, "after_rst");
        check_writes("after_rst");

        // Trap request held through a whole sequence
        @(negedge clk);
        bus.trap_req_i   = 1'b1;
        bus.trap_cause_i = 32'h0000_0004;
        bus.trap_pc_i    = 32'h0000_0700;
        #1;
        check("hold_ack", bus.trap_ack_o, 1);
        lat = 0;
        wait_redir(1'b0, lat);
        check("hold_lat", lat, 8);
        check("hold_pc", bus.redirect_pc_o, 32'h0000_1000);
        @(negedge clk);
        check("hold_ack2", bus.trap_ack_o, 1);
        @(negedge clk);
        bus.trap_req_i = 1'b0;
        lat = 1;
        wait_redir(1'b0, lat);
        check("hold_lat2", lat, 8);
        check("hold_pc2", bus.redirect_pc_o, 32'h0000_1000);
        @(negedge clk);
        check("hold_end", bus.busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
